// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic pipeline stage register with a valid/ready handshake, synchronous
// flush and an optional two-entry skid buffer. The stage carries one opaque
// DATA_W-bit payload. Empty or flushed slots present an all-zero payload,
// which the downstream stage decodes as a NOP bubble.
//
// Parameters:
//   DATA_W    payload width in bits (1..512, default 148)
//   SKID      1 = two-entry skid buffer with registered in_ready
//             0 = single register with combinational in_ready
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   flush      in   synchronous squash of held entries and same-cycle input
//   in_valid   in   upstream presents a payload
//   in_ready   out  stage accepts a payload this cycle
//   in_data    in   upstream payload
//   out_valid  out  out_data holds a live payload (flop output)
//   out_ready  in   downstream consumes out_data this cycle
//   out_data   out  head payload, all-zero when out_valid = 0 (flop output)
//   occupancy  out  number of live entries
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W = 148,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  logic in_xfer_s;
  logic out_xfer_s;

  // Handshake transfers, shared by both implementations
  assign in_xfer_s  = in_valid && in_ready;
  assign out_xfer_s = out_valid && out_ready;

  if (SKID != 0) begin : g_skid

    typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            nxt_state_s;
    logic [DATA_W-1:0] main_r;
    logic [DATA_W-1:0] skb_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [1:0]        occ_r;

    // Occupancy implied by a state
    function automatic logic [1:0] occ_of(input state_t st);
      logic [1:0] occ;
      case (st)
        ST_EMPTY: occ = 2'd0;
        ST_ONE:   occ = 2'd1;
        ST_FULL:  occ = 2'd2;
        default:  occ = 2'd0;
      endcase
      return occ;
    endfunction

    // Next state from the current state and this edge's transfers
    function automatic state_t next_state(
      input state_t cur,
      input logic   flush_i,
      input logic   in_x,
      input logic   out_x
    );
      state_t nxt;
      nxt = cur;
      if (flush_i) begin
        nxt = ST_EMPTY;
      end else begin
        case (cur)
          ST_EMPTY: begin
            if (in_x) nxt = ST_ONE;
            else      nxt = ST_EMPTY;
          end
          ST_ONE: begin
            if (in_x && !out_x)      nxt = ST_FULL;
            else if (!in_x && out_x) nxt = ST_EMPTY;
            else                     nxt = ST_ONE;
          end
          ST_FULL: begin
            if (out_x) nxt = ST_ONE;
            else       nxt = ST_FULL;
          end
          default: nxt = ST_EMPTY;
        endcase
      end
      return nxt;
    endfunction

    // Next state is needed both for the state flop and for the registered
    // in_ready / out_valid / occupancy, which all look one edge ahead.
    assign nxt_state_s = next_state(state_r, flush, in_xfer_s, out_xfer_s);

    // FSM, output register (MAIN), skid register (SKB) and registered flags
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r     <= ST_EMPTY;
        main_r      <= ZERO_DATA;
        skb_r       <= ZERO_DATA;
        in_ready_r  <= 1'b1;
        out_valid_r <= 1'b0;
        occ_r       <= 2'd0;
      end else begin
        state_r     <= nxt_state_s;
        in_ready_r  <= (nxt_state_s != ST_FULL);
        out_valid_r <= (nxt_state_s != ST_EMPTY);
        occ_r       <= occ_of(nxt_state_s);
        if (flush) begin
          // Any input accepted this cycle is dropped with the held entries
          main_r <= ZERO_DATA;
          skb_r  <= ZERO_DATA;
        end else begin
          case (state_r)
            ST_EMPTY: begin
              if (in_xfer_s) main_r <= in_data;
              else           main_r <= main_r;
            end
            ST_ONE: begin
              if (in_xfer_s && out_xfer_s) begin
                main_r <= in_data;
              end else if (in_xfer_s) begin
                // Downstream stalled: park the new payload behind MAIN
                skb_r <= in_data;
              end else if (out_xfer_s) begin
                main_r <= ZERO_DATA;
              end else begin
                main_r <= main_r;
              end
            end
            ST_FULL: begin
              // in_ready is low here, so only the drain can happen
              if (out_xfer_s) begin
                main_r <= skb_r;
                skb_r  <= ZERO_DATA;
              end else begin
                main_r <= main_r;
              end
            end
            default: begin
              main_r <= ZERO_DATA;
              skb_r  <= ZERO_DATA;
            end
          endcase
        end
      end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign occupancy = occ_r;

  end else begin : g_single

    logic [DATA_W-1:0] main_r;
    logic              valid_r;

    // Single output register; a simultaneous input and output is a
    // pass-through that replaces MAIN in place.
    always_ff @(posedge clk) begin
      if (rst) begin
        main_r  <= ZERO_DATA;
        valid_r <= 1'b0;
      end else if (flush) begin
        main_r  <= ZERO_DATA;
        valid_r <= 1'b0;
      end else if (in_xfer_s) begin
        main_r  <= in_data;
        valid_r <= 1'b1;
      end else if (out_xfer_s) begin
        main_r  <= ZERO_DATA;
        valid_r <= 1'b0;
      end else begin
        main_r  <= main_r;
        valid_r <= valid_r;
      end
    end

    // Combinational ready: room when empty or when the head leaves now
    assign in_ready  = !valid_r || out_ready;
    assign out_valid = valid_r;
    assign out_data  = main_r;
    assign occupancy = {1'b0, valid_r};

  end

  pipe_stage_reg_chk #(
    .DATA_W (DATA_W),
    .SKID   (SKID)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

endmodule

// ---------------------------------------------------------------------------
// pipe_stage_reg_chk
//
// Invariant checker for pipe_stage_reg. Observes outputs only.
//
// Ports:
//   clk, rst                       clock and synchronous reset of the stage
//   in_ready, out_valid, out_data  stage handshake outputs
//   occupancy                      stage entry count
// ---------------------------------------------------------------------------
module pipe_stage_reg_chk #(
  parameter int DATA_W = 148,
  parameter int SKID   = 1
) (
  input logic              clk,
  input logic              rst,
  input logic              in_ready,
  input logic              out_valid,
  input logic [DATA_W-1:0] out_data,
  input logic [1:0]        occupancy
);

  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  // Empty slot must look like a NOP bubble
  a_bubble_zero: assert property (@(posedge clk) disable iff (rst)
    !out_valid |-> (out_data == ZERO_DATA));

  // out_valid and occupancy describe the same head entry
  a_valid_occ: assert property (@(posedge clk) disable iff (rst)
    out_valid == (occupancy != 2'd0));

  if (SKID != 0) begin : g_skid_chk
    a_occ_range: assert property (@(posedge clk) disable iff (rst)
      occupancy <= 2'd2);
    // Registered ready mirrors "not full"
    a_ready_full: assert property (@(posedge clk) disable iff (rst)
      in_ready == (occupancy != 2'd2));
  end else begin : g_single_chk
    a_occ_range: assert property (@(posedge clk) disable iff (rst)
      occupancy <= 2'd1);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Four instances: (148,SKID=1), (148,SKID=0), (1,SKID=1), (1,SKID=0).
// The reference model is a FIFO queue per instance with capacity 2 (skid)
// or 1 (single). Stimulus pushes accepted payloads into the queue; a
// monitor on the falling edge compares the DUT against the queue and pops
// on every output transfer.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int N = 4;
  localparam int W = 148;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         fl   [N];
  logic         iv   [N];
  logic         orr  [N];
  logic [W-1:0] id   [N];
  logic         ir   [N];
  logic         ov   [N];
  logic [1:0]   occ  [N];
  logic [W-1:0] od0, od1;
  logic [0:0]   od2, od3;

  logic [W-1:0] sb_q      [N][$];
  logic         pend_push [N];
  logic         pend_clr  [N];
  logic [W-1:0] pend_data [N];

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(148), .SKID(1)) u0 (
    .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od0),
    .occupancy(occ[0]));
  pipe_stage_reg #(.DATA_W(148), .SKID(0)) u1 (
    .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od1),
    .occupancy(occ[1]));
  pipe_stage_reg #(.DATA_W(1), .SKID(1)) u2 (
    .clk(clk), .rst(rst), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(id[2][0:0]), .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od2),
    .occupancy(occ[2]));
  pipe_stage_reg #(.DATA_W(1), .SKID(0)) u3 (
    .clk(clk), .rst(rst), .flush(fl[3]), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_data(id[3][0:0]), .out_valid(ov[3]), .out_ready(orr[3]), .out_data(od3),
    .occupancy(occ[3]));

  function automatic logic [W-1:0] get_od(input int i);
    case (i)
      0:       return od0;
      1:       return od1;
      2:       return W'(od2);
      default: return W'(od3);
    endcase
  endfunction

  function automatic logic is_skid(input int i);
    return (i == 0) || (i == 2);
  endfunction

  function automatic logic [W-1:0] mask_of(input int i);
    logic [W-1:0] m;
    if (i < 2) m = {W{1'b1}};
    else       m = W'(1);
    return m;
  endfunction

  // Expected ready: skid accepts while fewer than two are held; single
  // accepts when empty or when the head leaves this cycle.
  function automatic logic model_ir(input int i);
    int sz;
    sz = sb_q[i].size();
    if (is_skid(i)) return sz < 2;
    else            return (sz == 0) || orr[i];
  endfunction

  task automatic chk(input string name, input int i,
                     input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s[u%0d] at %0t: got %0h, expected %0h", name, i, $time, act, req);
    end
  endtask

  // Monitor: compare every instance against its queue mid-cycle
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int i = 0; i < N; i++) begin
        logic [W-1:0] head;
        int           sz;
        sz   = sb_q[i].size();
        head = (sz > 0) ? sb_q[i][0] : {W{1'b0}};
        chk("occupancy", i, W'(occ[i]), W'(sz));
        chk("out_valid", i, W'(ov[i]), W'(sz > 0));
        chk("out_data",  i, get_od(i), head);
        chk("in_ready",  i, W'(ir[i]), W'(model_ir(i)));
        if (sz > 0 && orr[i]) void'(sb_q[i].pop_front());
      end
    end
  end

  // Record what the coming edge does to the model
  task automatic commit();
    for (int i = 0; i < N; i++) begin
      pend_clr[i]  = rst || fl[i];
      pend_push[i] = iv[i] && model_ir(i);
      pend_data[i] = id[i] & mask_of(i);
    end
  endtask

  // Advance one edge and apply its effect to the model
  task automatic step();
    commit();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (pend_clr[i])       sb_q[i].delete();
      else if (pend_push[i]) sb_q[i].push_back(pend_data[i]);
    end
  endtask

  task automatic set_in(input int i, input logic v, input logic [W-1:0] d,
                        input logic o, input logic f);
    iv[i] = v; id[i] = d; orr[i] = o; fl[i] = f;
  endtask

  task automatic idle_all(input logic o);
    for (int i = 0; i < N; i++) set_in(i, 1'b0, {W{1'b0}}, o, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle_all(1'b0);
    step();
    step();
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_out_valid", 0, W'(ov[0]), W'(0));
    chk("rst_occupancy", 0, W'(occ[0]), W'(0));
    chk("rst_out_data",  0, od0, W'(0));
    chk("rst_in_ready",  0, W'(ir[0]), W'(1));
    chk("rst_out_valid", 1, W'(ov[1]), W'(0));
    chk("rst_out_data",  1, od1, W'(0));

    // Stream 1..4 with out_ready held high: one-cycle latency, full rate
    for (int k = 1; k <= 4; k++) begin
      set_in(0, 1'b1, W'(k), 1'b1, 1'b0);
      set_in(1, 1'b1, W'(k), 1'b1, 1'b0);
      step();
      chk("stream", 0, od0, W'(k));
      chk("stream", 1, od1, W'(k));
    end
    idle_all(1'b1);
    step();
    step();

    // Back-pressure, skid mode
    set_in(0, 1'b1, W'('hA), 1'b1, 1'b0);
    step();
    set_in(0, 1'b1, W'('hB), 1'b0, 1'b0);
    step();
    chk("bp_occ_full", 0, W'(occ[0]), W'(2));
    chk("bp_head_A",   0, od0, W'('hA));
    set_in(0, 1'b1, W'('hC), 1'b0, 1'b0);
    #1;
    chk("bp_ready_low", 0, W'(ir[0]), W'(0));
    step();
    set_in(0, 1'b1, W'('hC), 1'b1, 1'b0);
    step();
    chk("bp_head_B", 0, od0, W'('hB));
    chk("bp_ready_back", 0, W'(ir[0]), W'(1));
    step();
    chk("bp_head_C", 0, od0, W'('hC));
    idle_all(1'b1);
    step();

    // Back-pressure, single mode: combinational ready
    set_in(1, 1'b1, W'('h7), 1'b0, 1'b0);
    step();
    set_in(1, 1'b1, W'('h8), 1'b0, 1'b0);
    #1;
    chk("s0_ready_low", 1, W'(ir[1]), W'(0));
    step();
    set_in(1, 1'b1, W'('h8), 1'b1, 1'b0);
    #1;
    chk("s0_ready_comb", 1, W'(ir[1]), W'(1));
    step();
    chk("s0_passthru", 1, od1, W'('h8));
    idle_all(1'b1);
    step();

    // Flush while FULL with a simultaneous input
    set_in(0, 1'b1, W'('h11), 1'b0, 1'b0);
    step();
    set_in(0, 1'b1, W'('h22), 1'b0, 1'b0);
    step();
    chk("fl_occ_full", 0, W'(occ[0]), W'(2));
    set_in(0, 1'b1, W'('h33), 1'b0, 1'b1);
    step();
    chk("fl_occ",       0, W'(occ[0]), W'(0));
    chk("fl_out_valid", 0, W'(ov[0]), W'(0));
    chk("fl_out_data",  0, od0, W'(0));
    idle_all(1'b1);
    step();
    step();
    chk("fl_no_33", 0, W'(ov[0]), W'(0));

    // Reset mid-stream with flush also asserted
    set_in(0, 1'b1, W'('h44), 1'b0, 1'b0);
    step();
    set_in(0, 1'b1, W'('h55), 1'b0, 1'b0);
    step();
    chk("mr_occ_full", 0, W'(occ[0]), W'(2));
    rst = 1'b1;
    set_in(0, 1'b1, W'('h66), 1'b1, 1'b1);
    step();
    rst = 1'b0;
    idle_all(1'b0);
    #1;
    chk("mr_out_valid", 0, W'(ov[0]), W'(0));
    chk("mr_occ",       0, W'(occ[0]), W'(0));
    chk("mr_out_data",  0, od0, W'(0));
    chk("mr_in_ready",  0, W'(ir[0]), W'(1));
    set_in(0, 1'b1, W'('h5), 1'b1, 1'b0);
    step();
    chk("mr_fresh", 0, od0, W'('h5));
    idle_all(1'b1);
    step();

    // Random soak, all four instances, about 2% flush
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        logic [W-1:0] d;
        d = W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        set_in(i, 1'($urandom_range(0, 1)), d & mask_of(i),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 2));
      end
      step();
    end
    idle_all(1'b1);
    step();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
